// File: rtl/mux_pkg.sv
// Shared types and helpers for the stream mux.
// Holds the selection mode enum and select-width function.
package mux_pkg;

  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_e;

  function automatic int sel_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first requester at or above ptr, wrapping N-1 to 0.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N     = 5,
  localparam int SEL_W = sel_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] index
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    index = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        index  = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-to-1 valid/ready stream mux with a single output register.
// Channel picked by fixed select or round-robin pointer.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter  int        WIDTH = 64,
  parameter  int        N     = 5,
  parameter  mux_mode_e MODE  = MUX_RR,
  localparam int        SEL_W = sel_w(N)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [N-1:0]              in_valid,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  output logic [N-1:0]              in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_src,
  input  logic                      out_ready,
  output logic                      sel_err
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_src_q, out_src_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_ok;
  logic [N-1:0]     arb_gnt;
  logic [SEL_W-1:0] arb_idx;
  logic [N-1:0]     rdy;
  logic [SEL_W-1:0] src_idx;
  logic             err_c;
  logic             in_xfer;
  logic             out_xfer;

  // Gating with reset_n keeps in_ready low while reset is held.
  assign load_ok = reset_n && (!out_valid_q || out_ready);

  rr_arbiter #(
    .N(N)
  ) u_arb (
    .req  (in_valid),
    .ptr  (ptr_q),
    .gnt  (arb_gnt),
    .index(arb_idx)
  );

  always_comb begin
    rdy     = '0;
    err_c   = 1'b0;
    src_idx = '0;
    if (MODE == MUX_FIXED) begin
      src_idx = sel;
      if (int'(sel) < N) rdy[sel] = load_ok;
      else               err_c    = load_ok;
    end else begin
      src_idx = arb_idx;
      rdy     = arb_gnt & {N{load_ok}};
    end
  end

  assign in_xfer  = |(rdy & in_valid);
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[src_idx];
      out_src_d   = src_idx;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    if (MODE == MUX_RR && in_xfer) begin
      ptr_d = (src_idx == SEL_W'(N - 1)) ? '0 : src_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign in_ready  = rdy;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign sel_err   = err_c;

endmodule

// File: doc/rr_stream_mux.md
RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning the data bits per channel.
REQ-002 The block SHALL have parameter N, default 5, meaning the number of input channels (legal range 2..16).
REQ-003 The block SHALL have parameter MODE, default MUX_RR, meaning the selection mode: MUX_FIXED or MUX_RR.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: the asynchronous, active-low reset.
REQ-006 The block SHALL have port in_valid, input, N bits: per-channel data valid.
REQ-007 The block SHALL have port in_data, input, N x WIDTH: per-channel data.
REQ-008 The block SHALL have port in_ready, output, N bits: per-channel accept.
REQ-009 The block SHALL have port sel, input, SEL_W bits: channel select, used only in MUX_FIXED mode.
REQ-010 The block SHALL have port out_valid, output, 1 bit: output register holds data.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: registered selected data.
REQ-012 The block SHALL have port out_src, output, SEL_W bits: index of the channel that supplied out_data.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts.
REQ-014 The block SHALL have port sel_err, output, 1 bit: one-cycle pulse on an illegal select.

Function
REQ-015 A transfer on channel i SHALL occur when in_valid[i] && in_ready[i] on a clock edge; an output transfer SHALL occur when out_valid && out_ready.
REQ-016 The output register SHALL be able to load (`load_ok`) when !out_valid || out_ready.
REQ-017 At most one in_ready bit SHALL be high per cycle; in_ready SHALL be combinational from in_valid, sel, pointer and load_ok, and SHALL never depend on out_data.
REQ-018 Latency SHALL be exactly 1 cycle: data accepted at edge k SHALL appear on out_data/out_src with out_valid=1 after edge k.
REQ-019 Throughput SHALL be one transfer per cycle when out_ready=1 continuously (no bubbles).
REQ-020 While out_valid && !out_ready, out_data, out_src and out_valid SHALL hold stable, and in_ready SHALL be all-zero.
REQ-021 If there is an output transfer and no input transfer in the same cycle, out_valid SHALL clear after the edge.
REQ-022 If there is an output transfer and an input transfer in the same cycle, the register SHALL reload with no bubble.
REQ-023 In MUX_FIXED mode, in_ready[sel] SHALL equal load_ok when sel < N, and all other in_ready bits SHALL be 0.
REQ-024 In MUX_FIXED mode, when sel >= N and load_ok=1, in_ready SHALL be all-zero and sel_err SHALL pulse high for that cycle; otherwise sel_err SHALL be 0.
REQ-025 In MUX_RR mode, the grant SHALL go to the first requesting channel searching upward with wrap from pointer p (N-1 wraps to 0).
REQ-026 In MUX_RR mode, after a grant to channel g, p SHALL become (g+1) mod N; with no transfer, p SHALL hold.
REQ-027 In MUX_RR mode, sel SHALL be ignored and sel_err SHALL be held at 0.
REQ-028 No starvation: with all N channels requesting and out_ready=1, each channel SHALL be granted exactly once in any N consecutive transfers.
REQ-029 With in_valid all-zero, there SHALL be no grant and p SHALL hold.

Reset
REQ-030 Asserting reset_n=0 SHALL, asynchronously, force out_valid=0, out_data=0, out_src=0, p=0 and sel_err=0.
REQ-031 During reset, in_ready SHALL be all-zero.
REQ-032 Reset mid-transfer SHALL discard held data, and no transfer SHALL be reported.
REQ-033 The first grant after deassertion SHALL start the search at channel 0.
REQ-034 Reset deassertion SHALL be assumed synchronised externally.

Structure
REQ-035 The shared package mux_pkg SHALL hold the mux_mode_e enum (MUX_FIXED, MUX_RR) and the function sel_w(N) = max(1, ceil(log2 N)); SEL_W SHALL equal sel_w(N).
REQ-036 The block SHALL contain one sub-module, rr_arbiter (parameter N; inputs req, ptr; outputs one-hot gnt and index), purely combinational.
REQ-037 The pointer register and output register SHALL reside in rr_stream_mux.

Verification
REQ-038 RR with all valid, out_ready=1, N=5: out_src SHALL read 0,1,2,3,4,0, with one transfer per cycle.
REQ-039 RR with valid={ch1,ch3}, p=2: ch3 SHALL be granted first, then ch1, then ch3.
REQ-040 Backpressure: with out_ready=0 for 3 cycles and out_data=0xA5A5, out_data SHALL stay stable, in_ready SHALL be 0, and no channel data SHALL be lost.
REQ-041 FIXED mode, sel=2 with ch2 data 0x1234: out_data SHALL be 0x1234 and out_src=2 one cycle later; sel=5 with N=5 SHALL produce sel_err=1 and no grant.
REQ-042 Assert reset_n=0 while out_valid=1 and p=3: outputs SHALL clear immediately; after release with all valid, channel 0 SHALL be granted first.
REQ-043 Simultaneous drain and load each cycle for 10 cycles: out_valid SHALL stay 1, with 10 transfers in and 10 out.
